hazard_ctrl_seq: RTL
====================

Name: hazard_ctrl_seq

Overview:
- Sequential successor to the combinational pipeline hazard unit of the 5-stage MIPS datapath.
- Adds three pieces of state:
  - parametrised multi-cycle load-use stalls;
  - a data-memory wait state driven by dhit and instruction-fetch wait handling;
  - a sticky halt.
- Sits beside the datapath and drives the PC enable plus all four pipeline-latch enable and flush controls; reports prediction hit status to the branch predictor.

Parameters:
- W_REG, 5, register-specifier width.
- LD_LAT, 1, bubble cycles inserted per load-use hazard; legal range 1..3.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- id_rs  in  W_REG  decode-stage rs
- id_rt  in  W_REG  decode-stage rt
- id_uses_rt  in  1  decode instruction reads rt
- ex_rd  in  W_REG  EX-stage destination
- ex_regWEN  in  1  EX-stage writes register
- ex_dmemREN  in  1  EX-stage instruction is a load
- mem_dREN  in  1  MEM-stage load
- mem_dWEN  in  1  MEM-stage store
- dhit  in  1  data memory access complete
- ihit  in  1  instruction fetch complete
- mem_branch  in  1  MEM-stage conditional branch
- mem_taken  in  1  resolved branch outcome
- mem_pred  in  1  predicted outcome carried down the pipe
- mem_redirect  in  1  MEM-stage JR/JAL (unconditional redirect)
- halt  in  1  halt reached MEM stage
- pcen  out  1  PC update enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  latch flushes (insert bubble)
- phit  out  1  prediction correct this cycle
- state  out  2  FSM state, debug

Behaviour:
- FSM states: RUN=0, LDSTALL=1, MEMWAIT=2, HALTED=3.
- Reset: state=RUN, stall counter=0.
- Output defaults (also the values out of reset in RUN with no hazard): all enables 1, all flushes 0, phit 1, pcen 1.
- Outputs are Mealy; priority applies top to bottom:
  1. HALTED: pcen=0; all enables 0; flushes 0. Sticky until RST.
  2. halt=1 in any state: pcen=0, mem_wb_flush=0 this cycle; next state HALTED.
  3. Memory wait: (mem_dREN|mem_dWEN)&!dhit.
     - pcen=0; if_id_en=id_ex_en=ex_mem_en=0; mem_wb_flush=1.
     - Next state MEMWAIT; remain while the condition holds.
     - On dhit=1: outputs return to default in that same cycle; next state RUN.
     - A stall counter loaded before entry is held, not decremented.
  4. Mispredict: mem_redirect | (mem_branch & (mem_taken!=mem_pred)).
     - phit=0; if_id_flush=id_ex_flush=ex_mem_flush=1; pcen=1.
     - Stall counter cleared; next state RUN (aborts LDSTALL).
  5. Load-use in RUN: ex_dmemREN & ex_regWEN & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
     - Outputs: id_ex_flush=1, if_id_en=0, pcen=0.
     - If LD_LAT>1: counter=LD_LAT-1, next state LDSTALL.
     - If LD_LAT=1: stay in RUN.
  6. LDSTALL: same outputs as load-use.
     - Counter decrements each cycle.
     - When counter==1 that is the last bubble; next state RUN.
  7. Fetch wait: !ihit in RUN or LDSTALL.
     - pcen=0.
     - In RUN with no other hazard: if_id_flush=1.
- mem_branch and mem_dREN/mem_dWEN are never both set (one instruction per stage); no combined case needs handling.
- RST asserted mid-stall or mid-wait: immediate return to RUN, counter 0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs:
  - stall_cycles [15:0]: counts cycles with pcen=0 in state RUN, LDSTALL or MEMWAIT.
  - mispredicts [15:0]: counts cycles with phit=0.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use, LD_LAT=3: ex_dmemREN=1, ex_regWEN=1, ex_rd=5, id_rs=5 -> 3 consecutive cycles of pcen=0, id_ex_flush=1, if_id_en=0; state 0->1->1->0.
- Same with ex_rd=0, or id_rt=5 with id_uses_rt=0 -> no stall; outputs stay at defaults.
- mem_dREN=1, dhit=0 for 4 cycles, then dhit=1 -> 4 cycles of pcen=0, mem_wb_flush=1, state=2; release in the dhit cycle with state=0.
- mem_branch=1, mem_taken=1, mem_pred=0 during LDSTALL (LD_LAT=3, second bubble) -> phit=0, three flushes, pcen=1; next cycle state=0 with no further bubble.
- halt=1 for one cycle then 0 -> pcen=0 and all enables 0 permanently; state=3 until RST; RST pulse -> state=0, defaults restored asynchronously.
- HAZARD_PERF_EN defined: the memory-wait scenario plus one mispredict -> stall_cycles=4, mispredicts=1.

Source files
------------

// File: rtl/hazard_ctrl_seq.sv
// rtl/hazard_ctrl_seq.sv - sequential pipeline hazard control (optional counters: HAZARD_PERF_EN)
module hazard_ctrl_seq #(
    parameter int W_REG  = 5,
    parameter int LD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W_REG-1:0] id_rs,
    input  logic [W_REG-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [W_REG-1:0] ex_rd,
    input  logic             ex_regWEN,
    input  logic             ex_dmemREN,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             mem_branch,
    input  logic             mem_taken,
    input  logic             mem_pred,
    input  logic             mem_redirect,
    input  logic             halt,
    output logic             pcen,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             phit,
    output logic [1:0]       state
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      mispredicts
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    // Counter reload leaves LD_LAT-1 bubbles for LDSTALL after the first one in RUN.
    localparam logic [1:0] LD_RELOAD = 2'(LD_LAT - 1);

    state_t     cur;
    state_t     nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       mem_wait;
    logic       mispredict;
    logic       load_use;

    assign mem_wait   = (mem_dREN | mem_dWEN) & ~dhit;
    assign mispredict = mem_redirect | (mem_branch & (mem_taken != mem_pred));
    assign load_use   = ex_dmemREN & ex_regWEN & (ex_rd != '0) &
                        ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign state      = cur;

    // Prioritised Mealy decode of pipeline controls and next FSM state.
    always_comb begin
        pcen         = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        phit         = 1'b1;
        nxt          = cur;
        cnt_nxt      = cnt;
        if (cur == HALTED) begin
            pcen      = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (halt) begin
            pcen = 1'b0;
            nxt  = HALTED;
        end else if (mem_wait) begin
            pcen         = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            nxt          = MEMWAIT;
        end else if (cur == MEMWAIT) begin
            nxt = RUN;
        end else if (mispredict) begin
            phit         = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_nxt      = 2'd0;
            nxt          = RUN;
        end else if ((cur == RUN && load_use) || cur == LDSTALL) begin
            pcen        = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (cur == RUN) begin
                if (LD_LAT > 1) begin
                    cnt_nxt = LD_RELOAD;
                    nxt     = LDSTALL;
                end
            end else begin
                cnt_nxt = 2'(cnt - 2'd1);
                if (cnt == 2'd1) begin
                    nxt = RUN;
                end
            end
        end else if (!ihit) begin
            pcen        = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // State and stall counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur <= RUN;
            cnt <= 2'd0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating stall and mispredict event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= 16'd0;
            mispredicts  <= 16'd0;
        end else begin
            if (!pcen && cur != HALTED && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (!phit && mispredicts != 16'hFFFF) begin
                mispredicts <= mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule
